// File: rtl/logic_vector_seq_pkg.sv
// Shared types and constants for the logic vector sequencer.
// Holds FSM state type, result width, expected-response table and a helper.
package logic_vector_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_EMIT,
      S_DONE
   } state_t;

   localparam int RES_W = 6;

   // Expected {X,Y,Z} per index {A,B,C}:
   // X = parity, Y = majority, Z = all-zero.
   localparam logic [2:0] EXP_TABLE [0:7] = '{
      3'b001, 3'b100, 3'b100, 3'b010,
      3'b100, 3'b010, 3'b010, 3'b110
   };

   // Returns {found, index} of the lowest set bit.
   function automatic logic [3:0] first_set(
      input logic [7:0] m
   );
      logic [3:0] r;
      r = 4'b0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/logic_vector_seq_settle_timer.sv
// Settle down-counter: loaded with SETTLE_CYCLES, expires on final count.
// Ports: i_clk, i_rst (sync high), i_load, i_count, o_expire.
module seq_settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_count,
   output logic o_expire
);

   logic [3:0] r_cnt;

   assign o_expire = i_count && (r_cnt == 4'd1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= 4'(SETTLE_CYCLES);
      end else if (i_count && r_cnt > 4'd1) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

endmodule

// File: rtl/logic_vector_seq.sv
// Steps masked 3-bit vectors onto A/B/C, captures X/Y/Z, streams results.
// Ports: clk_in, rst_in (sync high), start_in, mask_in[7:0],
//   A/B/C_out, X/Y/Z_in, res_valid_out, res_ready_in,
//   res_data_out[5:0] = {idx,X,Y,Z}, busy_out, done_out.
// Macro LOGIC_VECTOR_SEQ_CHECK_EN adds mismatch_out and err_cnt_out[3:0].
module logic_vector_seq
   import logic_vector_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_VEC       = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [7:0]       mask_in,
   output logic             A_out,
   output logic             B_out,
   output logic             C_out,
   input  logic             X_in,
   input  logic             Y_in,
   input  logic             Z_in,
   output logic             res_valid_out,
   input  logic             res_ready_in,
   output logic [RES_W-1:0] res_data_out,
   output logic             busy_out,
   output logic             done_out
`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
   ,
   output logic             mismatch_out,
   output logic [3:0]       err_cnt_out
`endif
);

   localparam logic [7:0] VEC_MASK =
      8'((64'd1 << NUM_VEC) - 64'd1);

   state_t           r_state;
   logic [7:0]       r_mask;
   logic [2:0]       r_idx;
   logic             r_valid;
   logic [RES_W-1:0] r_data;
   logic             r_busy;
   logic             r_done;

   logic [3:0] w_first;
   logic [3:0] w_next;
   logic [2:0] w_xyz;
   logic       w_accept;
   logic       w_xfer;
   logic       w_load;
   logic       w_count;
   logic       w_expire;

   assign w_xyz    = {X_in, Y_in, Z_in};
   assign w_accept = (r_state == S_IDLE) && start_in;
   assign w_xfer   = r_valid && res_ready_in;
   assign w_first  = first_set(mask_in & VEC_MASK);
   // Only bits strictly above idx, so the index never wraps.
   assign w_next   = first_set(r_mask & (8'hFE << r_idx));
   assign w_load   = w_accept || w_xfer;
   assign w_count  = (r_state == S_APPLY);

   seq_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .i_clk    (clk_in),
      .i_rst    (rst_in),
      .i_load   (w_load),
      .i_count  (w_count),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_mask  <= 8'd0;
         r_idx   <= 3'd0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_mask <= mask_in & VEC_MASK;
                  r_busy <= 1'b1;
                  r_idx  <= w_first[2:0];
                  if (w_first[3]) begin
                     r_state <= S_APPLY;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_APPLY: begin
               if (w_expire) begin
                  r_data  <= {r_idx, w_xyz};
                  r_valid <= 1'b1;
                  r_state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (w_xfer) begin
                  r_valid <= 1'b0;
                  if (w_next[3]) begin
                     r_idx   <= w_next[2:0];
                     r_state <= S_APPLY;
                  end else begin
                     r_idx   <= 3'd0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign {A_out, B_out, C_out} = r_idx;
   assign res_valid_out = r_valid;
   assign res_data_out  = r_data;
   assign busy_out      = r_busy;
   assign done_out      = r_done;

`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
   logic       r_mism;
   logic [3:0] r_err;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_mism <= 1'b0;
         r_err  <= 4'd0;
      end else begin
         if (w_accept) begin
            r_err <= 4'd0;
         end
         if (w_count && w_expire) begin
            r_mism <= (w_xyz != EXP_TABLE[r_idx]);
         end
         if (w_xfer) begin
            r_mism <= 1'b0;
            if (r_mism && r_err != 4'hF) begin
               r_err <= r_err + 4'd1;
            end
         end
      end
   end

   assign mismatch_out = r_mism;
   assign err_cnt_out  = r_err;
`else
   // Unchecked build: responses are passed through uncompared.
`endif

endmodule

// File: tb/tb_logic_vector_seq.sv
// Directed self-checking bench for logic_vector_seq (SETTLE_CYCLES=2).
// Responder models X=parity, Y=majority, Z=all-zero of {A,B,C}.
module tb_logic_vector_seq;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       start_in;
   logic [7:0] mask_in;
   logic       A_out, B_out, C_out;
   logic       X_in, Y_in, Z_in;
   logic       res_valid_out;
   logic       res_ready_in;
   logic [5:0] res_data_out;
   logic       busy_out;
   logic       done_out;
`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
   logic       mismatch_out;
   logic [3:0] err_cnt_out;
`endif
   logic       inj;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk_in = ~clk_in;

   logic_vector_seq #(
      .SETTLE_CYCLES (2),
      .NUM_VEC       (8)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .mask_in       (mask_in),
      .A_out         (A_out),
      .B_out         (B_out),
      .C_out         (C_out),
      .X_in          (X_in),
      .Y_in          (Y_in),
      .Z_in          (Z_in),
      .res_valid_out (res_valid_out),
      .res_ready_in  (res_ready_in),
      .res_data_out  (res_data_out),
      .busy_out      (busy_out),
      .done_out      (done_out)
`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
      ,
      .mismatch_out  (mismatch_out),
      .err_cnt_out   (err_cnt_out)
`endif
   );

   function automatic logic [2:0] model(input logic [2:0] i);
      logic x, y, z;
      x = i[2] ^ i[1] ^ i[0];
      y = (i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]);
      z = (i == 3'd0);
      return {x, y, z};
   endfunction

   function automatic logic flip(input logic [2:0] i);
      return inj && (i == 3'd1 || i == 3'd6);
   endfunction

   logic [2:0] abc;
   assign abc = {A_out, B_out, C_out};
   assign {X_in, Y_in, Z_in} = model(abc) ^ {flip(abc), 2'b00};

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h",
                  tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".abc"}, 32'(abc), 32'd0);
      chk({tag, ".valid"}, 32'(res_valid_out), 32'd0);
      chk({tag, ".data"}, 32'(res_data_out), 32'd0);
      chk({tag, ".busy"}, 32'(busy_out), 32'd0);
      chk({tag, ".done"}, 32'(done_out), 32'd0);
`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
      chk({tag, ".mism"}, 32'(mismatch_out), 32'd0);
      chk({tag, ".err"}, 32'(err_cnt_out), 32'd0);
`endif
   endtask

   task automatic start_run(input logic [7:0] m);
      start_in = 1'b1;
      mask_in  = m;
      tick();
      start_in = 1'b0;
      mask_in  = 8'h00;
   endtask

   // Called at the first APPLY cycle; ends in EMIT.
   task automatic vec(input logic [2:0] i);
      logic [2:0] e;
      e = model(i) ^ {flip(i), 2'b00};
      chk($sformatf("apply%0d.abc", i), 32'(abc), 32'(i));
      chk($sformatf("apply%0d.valid", i), 32'(res_valid_out), 32'd0);
      tick();
      chk($sformatf("settle%0d.valid", i), 32'(res_valid_out), 32'd0);
      tick();
      chk($sformatf("emit%0d.valid", i), 32'(res_valid_out), 32'd1);
      chk($sformatf("emit%0d.data", i), 32'(res_data_out),
          32'({i, e}));
      chk($sformatf("emit%0d.abc", i), 32'(abc), 32'(i));
`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
      chk($sformatf("emit%0d.mism", i), 32'(mismatch_out),
          32'(flip(i)));
`endif
   endtask

   task automatic finish_done(input string tag);
      chk({tag, ".done"}, 32'(done_out), 32'd1);
      chk({tag, ".valid"}, 32'(res_valid_out), 32'd0);
      chk({tag, ".abc"}, 32'(abc), 32'd0);
      tick();
      chk({tag, ".done_drop"}, 32'(done_out), 32'd0);
      chk({tag, ".busy_drop"}, 32'(busy_out), 32'd0);
   endtask

   initial begin
      rst_in       = 1'b1;
      start_in     = 1'b0;
      mask_in      = 8'h00;
      res_ready_in = 1'b1;
      inj          = 1'b0;
      tick();
      tick();
      chk_zero("reset");
      rst_in = 1'b0;
      tick();

      // Full sweep, one result every 3 cycles.
      start_run(8'hFF);
      chk("sweep.busy", 32'(busy_out), 32'd1);
      for (int i = 0; i < 8; i++) begin
         vec(3'(i));
         tick();
      end
      finish_done("sweep");
`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
      chk("sweep.err", 32'(err_cnt_out), 32'd0);
`endif

      // Sparse mask: idx 2 then 5.
      start_run(8'b0010_0100);
      vec(3'd2);
      tick();
      vec(3'd5);
      tick();
      finish_done("sparse");

      // Backpressure on idx 3.
      start_run(8'b0000_1100);
      vec(3'd2);
      tick();
      vec(3'd3);
      res_ready_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp.valid", 32'(res_valid_out), 32'd1);
         chk("bp.data", 32'(res_data_out), 32'({3'd3, 3'b010}));
         chk("bp.abc", 32'(abc), 32'd3);
      end
      res_ready_in = 1'b1;
      tick();
      finish_done("bp");

      // Empty mask.
      start_run(8'h00);
      finish_done("empty");

      // Start pulse while busy is ignored.
      start_run(8'b1000_0001);
      chk("busy_start.abc", 32'(abc), 32'd0);
      start_in = 1'b1;
      mask_in  = 8'hFF;
      tick();
      start_in = 1'b0;
      mask_in  = 8'h00;
      tick();
      chk("busy_start.valid", 32'(res_valid_out), 32'd1);
      chk("busy_start.data", 32'(res_data_out),
          32'({3'd0, 3'b001}));
      tick();
      vec(3'd7);
      tick();
      finish_done("busy_start");

      // Reset during idx 4 APPLY.
      start_run(8'hFF);
      for (int i = 0; i < 4; i++) begin
         vec(3'(i));
         tick();
      end
      chk("midrst.abc4", 32'(abc), 32'd4);
      tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk_zero("midrst");
      tick();
      chk("midrst.no_done", 32'(done_out), 32'd0);
      start_run(8'b0100_0010);
      chk("restart.busy", 32'(busy_out), 32'd1);
      vec(3'd1);
      tick();
      vec(3'd6);
      tick();
      finish_done("restart");

`ifdef LOGIC_VECTOR_SEQ_CHECK_EN
      // Inverted X on idx 1 and 6.
      inj = 1'b1;
      start_run(8'hFF);
      for (int i = 0; i < 8; i++) begin
         vec(3'(i));
         tick();
      end
      chk("inj.err_at_done", 32'(err_cnt_out), 32'd2);
      finish_done("inj");
      inj = 1'b0;
      start_run(8'h01);
      chk("inj.err_clear", 32'(err_cnt_out), 32'd0);
      vec(3'd0);
      tick();
      finish_done("clean");
      chk("clean.err", 32'(err_cnt_out), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
